// File: rtl/secuenciador_lectura_rtc.sv
// secuenciador_lectura_rtc
//   Sweeps the RTC time/date/timer registers over the shared RTC bus. Each
//   register gets one bus read followed by a single-cycle active-low reg_rd
//   strobe with addr_mem_local = local index, so the hold decoder releases
//   only that register. Single user writes are slotted in between sweep reads.
//   Optional feature macro: SWEEP_TIMEOUT_EN (bus_done wait limit, sticky bus_err).
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   start_sweep       : 1-cycle pulse, request one full sweep
//   wr_req            : user write request (level, held until wr_ack)
//   bus_done          : 1-cycle pulse, bus transaction complete
//   bus_req/bus_wr/bus_addr : transaction request, direction and RTC address
//   addr_mem_local, reg_rd  : local index and active-low latch strobe to decoder
//   wr_ack            : 1-cycle pulse, user write finished
//   busy              : high outside IDLE
//   sweep_done        : 1-cycle pulse after the last register is latched
//   bus_err           : sticky timeout flag (constant 0 without the macro)
module secuenciador_lectura_rtc #(
    parameter int unsigned N_REGS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_sweep,
    input  logic       wr_req,
    input  logic       bus_done,
    output logic       bus_req,
    output logic       bus_wr,
    output logic [7:0] bus_addr,
    output logic [3:0] addr_mem_local,
    output logic       reg_rd,
    output logic       wr_ack,
    output logic       busy,
    output logic       sweep_done,
    output logic       bus_err
);

    localparam int unsigned IDX_W  = 4;
    localparam int unsigned ADDR_W = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

`ifdef SWEEP_TIMEOUT_EN
    localparam int unsigned TIMEOUT_CYC = 255;
    localparam int unsigned TMO_W       = 8;
`endif

    logic [2:0]        state, state_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic              sweep_pend, pend_n;
    logic              in_sweep, in_sweep_n;
    logic              wr_ack_n;
    logic              bus_req_n, bus_wr_n, reg_rd_n, busy_n, sweep_done_n;
    logic [ADDR_W-1:0] bus_addr_n;
    logic [IDX_W-1:0]  addr_mem_local_n;

`ifdef SWEEP_TIMEOUT_EN
    logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_n;
    logic              bus_err_q, bus_err_n;
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    // Local register index to RTC bus address
    function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] i);
        case (i)
            4'd0:    addr_of = 8'h21;
            4'd1:    addr_of = 8'h22;
            4'd2:    addr_of = 8'h23;
            4'd3:    addr_of = 8'h24;
            4'd4:    addr_of = 8'h25;
            4'd5:    addr_of = 8'h26;
            4'd6:    addr_of = 8'h27;
            4'd7:    addr_of = 8'h41;
            4'd8:    addr_of = 8'h42;
            4'd9:    addr_of = 8'h43;
            default: addr_of = 8'h00;
        endcase
    endfunction

    // Next state, bookkeeping and next registered output values
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        pend_n     = sweep_pend;
        in_sweep_n = in_sweep;
        wr_ack_n   = 1'b0;
`ifdef SWEEP_TIMEOUT_EN
        bus_err_n  = bus_err_q;
        tmo_cnt_n  = '0;
`endif

        case (state)
            S_IDLE: begin
                if (wr_req) begin
                    state_n = S_WR;
                    if (start_sweep) pend_n = 1'b1;
                end else if (start_sweep || sweep_pend) begin
                    state_n    = S_RD;
                    idx_n      = '0;
                    pend_n     = 1'b0;
                    in_sweep_n = 1'b1;
                end
            end
            S_RD: begin
                if (bus_done) state_n = S_LATCH;
            end
            S_LATCH: begin
                if (idx == IDX_W'(N_REGS - 1)) begin
                    state_n = S_DONE;
                end else begin
                    idx_n   = idx + IDX_W'(1);
                    state_n = wr_req ? S_WR : S_RD;
                end
            end
            S_WR: begin
                if (bus_done) begin
                    wr_ack_n = 1'b1;
                    state_n  = in_sweep ? S_RD : S_IDLE;
                end
            end
            S_DONE: begin
                // Requests that arrived during this sweep survive to start the next one
                state_n    = S_IDLE;
                idx_n      = '0;
                in_sweep_n = 1'b0;
            end
            default: state_n = S_IDLE;
        endcase

        // A start request while busy is remembered once; repeats do not stack
        if (start_sweep && state != S_IDLE) pend_n = 1'b1;

`ifdef SWEEP_TIMEOUT_EN
        // Wait counter restarts on every RD/WR entry; expiry aborts the whole sweep
        if ((state == S_RD || state == S_WR) && !bus_done) begin
            if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                state_n    = S_IDLE;
                idx_n      = '0;
                pend_n     = 1'b0;
                in_sweep_n = 1'b0;
                bus_err_n  = 1'b1;
                wr_ack_n   = (state == S_WR);
            end else begin
                tmo_cnt_n = tmo_cnt + TMO_W'(1);
            end
        end
`endif

        bus_req_n        = (state_n == S_RD) || (state_n == S_WR);
        bus_wr_n         = (state_n == S_WR);
        bus_addr_n       = (state_n == S_RD) ? addr_of(idx_n) : 8'h00;
        reg_rd_n         = (state_n != S_LATCH);
        addr_mem_local_n = (state_n == S_LATCH) ? idx_n : 4'hF;
        busy_n           = (state_n != S_IDLE);
        sweep_done_n     = (state_n == S_DONE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            idx            <= '0;
            sweep_pend     <= 1'b0;
            in_sweep       <= 1'b0;
            bus_req        <= 1'b0;
            bus_wr         <= 1'b0;
            bus_addr       <= 8'h00;
            addr_mem_local <= 4'hF;
            reg_rd         <= 1'b1;
            wr_ack         <= 1'b0;
            busy           <= 1'b0;
            sweep_done     <= 1'b0;
`ifdef SWEEP_TIMEOUT_EN
            tmo_cnt        <= '0;
            bus_err_q      <= 1'b0;
`endif
        end else begin
            state          <= state_n;
            idx            <= idx_n;
            sweep_pend     <= pend_n;
            in_sweep       <= in_sweep_n;
            bus_req        <= bus_req_n;
            bus_wr         <= bus_wr_n;
            bus_addr       <= bus_addr_n;
            addr_mem_local <= addr_mem_local_n;
            reg_rd         <= reg_rd_n;
            wr_ack         <= wr_ack_n;
            busy           <= busy_n;
            sweep_done     <= sweep_done_n;
`ifdef SWEEP_TIMEOUT_EN
            tmo_cnt        <= tmo_cnt_n;
            bus_err_q      <= bus_err_n;
`endif
        end
    end

endmodule

// File: tb/tb_secuenciador_lectura_rtc.sv
// tb_secuenciador_lectura_rtc
//   Directed + randomized-latency bench for secuenciador_lectura_rtc. A bus
//   responder answers each transaction after a programmable latency, a monitor
//   logs bus transactions, strobes and pulses, and the main sequence compares
//   the logs against sequences and cycle counts derived from the register
//   address table and the per-register cost of latency+2 cycles.
module tb_secuenciador_lectura_rtc;

    logic       clk;
    logic       reset;
    logic       start_sweep;
    logic       wr_req;
    logic       bus_done;
    logic       bus_req;
    logic       bus_wr;
    logic [7:0] bus_addr;
    logic [3:0] addr_mem_local;
    logic       reg_rd;
    logic       wr_ack;
    logic       busy;
    logic       sweep_done;
    logic       bus_err;

    secuenciador_lectura_rtc dut (
        .clk            (clk),
        .reset          (reset),
        .start_sweep    (start_sweep),
        .wr_req         (wr_req),
        .bus_done       (bus_done),
        .bus_req        (bus_req),
        .bus_wr         (bus_wr),
        .bus_addr       (bus_addr),
        .addr_mem_local (addr_mem_local),
        .reg_rd         (reg_rd),
        .wr_ack         (wr_ack),
        .busy           (busy),
        .sweep_done     (sweep_done),
        .bus_err        (bus_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] addr_tab [10];

    // Responder controls (written by the main sequence)
    int   fix_lat   = 4;
    bit   spur_done = 0;
    bit   hold_en   = 0;
    logic [7:0] hold_addr = 8'h00;

    // Logs
    bit   txn_wr   [$];
    logic [7:0] txn_addr [$];
    int   txn_cyc  [$];
    logic [3:0] st_idx [$];
    int   st_cyc   [$];
    int   lat_log  [$];
    int   ack_cnt  = 0;
    int   sd_cnt   = 0;
    int   sd_cyc   = 0;
    int   wide_cnt = 0;
    int   idle_addr_bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Bus responder: bus_done is high in the cycle lat cycles after the one where the request appears
    initial begin
        bit r_prev_req;
        bit r_prev_done;
        bit active;
        bit new_t;
        int rem;
        int lat;
        r_prev_req  = 0;
        r_prev_done = 0;
        active      = 0;
        rem         = 0;
        bus_done    = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            new_t       = bus_req && (!r_prev_req || r_prev_done);
            r_prev_req  = bus_req;
            r_prev_done = bus_done;
            if (!bus_req) active = 0;
            if (new_t) begin
                lat = (fix_lat != 0) ? fix_lat : int'($urandom_range(1, 6));
                lat_log.push_back(lat);
                rem    = lat;
                active = !(hold_en && !bus_wr && bus_addr == hold_addr);
            end else if (rem > 0) begin
                rem--;
            end
            bus_done = spur_done || (active && rem == 0);
            if (active && rem == 0) active = 0;
        end
    end

    // Monitor, sampled mid-cycle
    always @(negedge clk) begin
        bit prev_req;
        bit prev_done;
        bit prev_rd;
        if (bus_req && (!prev_req || prev_done)) begin
            txn_wr.push_back(bus_wr);
            txn_addr.push_back(bus_addr);
            txn_cyc.push_back(cyc);
        end
        if (reg_rd === 1'b0) begin
            st_idx.push_back(addr_mem_local);
            st_cyc.push_back(cyc);
            if (!prev_rd) wide_cnt++;
        end else if (addr_mem_local !== 4'hF) begin
            idle_addr_bad++;
        end
        if (wr_ack) ack_cnt++;
        if (sweep_done) begin
            sd_cnt++;
            sd_cyc = cyc;
        end
        prev_req  = bus_req;
        prev_done = bus_done;
        prev_rd   = (reg_rd !== 1'b0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        txn_wr.delete();
        txn_addr.delete();
        txn_cyc.delete();
        st_idx.delete();
        st_cyc.delete();
        lat_log.delete();
        ack_cnt       = 0;
        sd_cnt        = 0;
        wide_cnt      = 0;
        idle_addr_bad = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_bus_req"},  32'(bus_req),        32'd0);
        check({tag, "_bus_wr"},   32'(bus_wr),         32'd0);
        check({tag, "_bus_addr"}, 32'(bus_addr),       32'h00);
        check({tag, "_addr_loc"}, 32'(addr_mem_local), 32'hF);
        check({tag, "_reg_rd"},   32'(reg_rd),         32'd1);
        check({tag, "_wr_ack"},   32'(wr_ack),         32'd0);
        check({tag, "_busy"},     32'(busy),           32'd0);
        check({tag, "_sweep_dn"}, 32'(sweep_done),     32'd0);
        check({tag, "_bus_err"},  32'(bus_err),        32'd0);
    endtask

    task automatic wait_sweeps(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (sd_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        check({tag, "_sweep_seen"}, 32'(sd_cnt >= target), 32'd1);
    endtask

    task automatic serve_write(input int budget, input string tag);
        int n;
        n = 0;
        while (!wr_ack && n < budget) begin
            tick(1);
            n++;
        end
        wr_req = 1'b0;
        check({tag, "_wr_ack_seen"}, 32'(wr_ack), 32'd1);
    endtask

    task automatic wait_txns(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (txn_addr.size() < target && n < budget) begin
            tick(1);
            n++;
        end
        check({tag, "_txn_seen"}, 32'(txn_addr.size() >= target), 32'd1);
    endtask

    // Ten reads in table order starting at log position base
    task automatic check_reads(input int base, input string tag);
        if (txn_addr.size() >= base + 10) begin
            for (int k = 0; k < 10; k++)
                check($sformatf("%s_rd%0d", tag, k),
                      {23'd0, txn_wr[base+k], txn_addr[base+k]}, {24'd0, addr_tab[k]});
        end else begin
            check({tag, "_rd_count"}, 32'(txn_addr.size()), 32'(base + 10));
        end
    endtask

    // Ten single-cycle strobes with local indices 0..9
    task automatic check_strobes(input int base, input string tag);
        if (st_idx.size() >= base + 10) begin
            for (int k = 0; k < 10; k++)
                check($sformatf("%s_st%0d", tag, k), 32'(st_idx[base+k]), 32'(k));
        end else begin
            check({tag, "_st_count"}, 32'(st_idx.size()), 32'(base + 10));
        end
        check({tag, "_st_width"}, 32'(wide_cnt), 32'd0);
        check({tag, "_idle_addr"}, 32'(idle_addr_bad), 32'd0);
    endtask

    initial begin
        int t0;
        int exp_cyc;
        addr_tab[0] = 8'h21; addr_tab[1] = 8'h22; addr_tab[2] = 8'h23;
        addr_tab[3] = 8'h24; addr_tab[4] = 8'h25; addr_tab[5] = 8'h26;
        addr_tab[6] = 8'h27; addr_tab[7] = 8'h41; addr_tab[8] = 8'h42;
        addr_tab[9] = 8'h43;

        reset       = 1'b1;
        start_sweep = 1'b0;
        wr_req      = 1'b0;
        tick(3);
        check_idle_outputs("reset");
        reset = 1'b0;
        tick(2);

        // Spurious bus_done in IDLE is ignored
        clear_logs();
        spur_done = 1;
        tick(1);
        spur_done = 0;
        tick(3);
        check("spur_busy", 32'(busy), 32'd0);
        check("spur_txn",  32'(txn_addr.size()), 32'd0);

        // Plain sweep, latency 4: register k strobed (k+1)*6 cycles after start_sweep,
        // sweep_done 61 cycles after (a 62-cycle window counting both ends)
        clear_logs();
        fix_lat = 4;
        start_sweep = 1'b1;
        t0 = cyc;
        tick(1);
        start_sweep = 1'b0;
        wait_sweeps(1, 200, "sweep4");
        check_reads(0, "sweep4");
        check_strobes(0, "sweep4");
        for (int k = 0; k < 10 && k < st_cyc.size(); k++)
            check($sformatf("sweep4_stcyc%0d", k), 32'(st_cyc[k] - t0), 32'((k + 1) * 6));
        check("sweep4_done_cyc", 32'(sd_cyc - t0), 32'(10 * (4 + 2) + 1));
        check("sweep4_busy_end", 32'(busy), 32'd0);

        // Random per-transaction latency: total time is the sum of (lat+2) plus one
        for (int r = 0; r < 3; r++) begin
            clear_logs();
            fix_lat = 0;
            tick(1 + int'($urandom_range(0, 3)));
            start_sweep = 1'b1;
            t0 = cyc;
            tick(1);
            start_sweep = 1'b0;
            wait_sweeps(1, 300, $sformatf("rnd%0d", r));
            exp_cyc = 1;
            foreach (lat_log[i]) exp_cyc += lat_log[i] + 2;
            check($sformatf("rnd%0d_done_cyc", r), 32'(sd_cyc - t0), 32'(exp_cyc));
            check_reads(0, $sformatf("rnd%0d", r));
            check_strobes(0, $sformatf("rnd%0d", r));
        end

        // Write raised during the read of index 2 goes out right after its strobe
        clear_logs();
        fix_lat = 3;
        start_sweep = 1'b1;
        tick(1);
        start_sweep = 1'b0;
        wait_txns(3, 100, "wr_mid");
        wr_req = 1'b1;
        serve_write(100, "wr_mid");
        wait_sweeps(1, 200, "wr_mid");
        check("wr_mid_txn_count", 32'(txn_addr.size()), 32'd11);
        if (txn_addr.size() >= 5 && st_cyc.size() >= 3) begin
            check("wr_mid_is_write", 32'(txn_wr[3]),   32'd1);
            check("wr_mid_wr_addr",  32'(txn_addr[3]), 32'h00);
            check("wr_mid_wr_cyc",   32'(txn_cyc[3]),  32'(st_cyc[2] + 1));
            check("wr_mid_resume",   {23'd0, txn_wr[4], txn_addr[4]}, 32'h24);
        end
        check("wr_mid_ack_cnt", 32'(ack_cnt), 32'd1);
        check_strobes(0, "wr_mid");

        // start_sweep and wr_req together: write first, then a full sweep
        tick(2);
        clear_logs();
        start_sweep = 1'b1;
        wr_req      = 1'b1;
        tick(1);
        start_sweep = 1'b0;
        serve_write(100, "both");
        wait_sweeps(1, 200, "both");
        check("both_first_write", {23'd0, txn_wr[0], txn_addr[0]}, 32'h100);
        txn_wr.pop_front();
        txn_addr.pop_front();
        check_reads(0, "both");
        check("both_ack_cnt", 32'(ack_cnt), 32'd1);

        // Three start pulses during a sweep give exactly one extra sweep
        tick(2);
        clear_logs();
        fix_lat = 2;
        start_sweep = 1'b1;
        tick(1);
        start_sweep = 1'b0;
        wait_txns(2, 50, "multi");
        for (int p = 0; p < 3; p++) begin
            start_sweep = 1'b1;
            tick(1);
            start_sweep = 1'b0;
            tick(4);
        end
        wait_sweeps(2, 300, "multi");
        tick(100);
        check("multi_sweep_cnt", 32'(sd_cnt), 32'd2);
        check("multi_txn_cnt",   32'(txn_addr.size()), 32'd20);
        check_reads(0, "multi_a");
        check_reads(10, "multi_b");
        check("multi_busy_end", 32'(busy), 32'd0);

        // Reset during the read of index 3 discards the sweep
        clear_logs();
        fix_lat = 5;
        start_sweep = 1'b1;
        tick(1);
        start_sweep = 1'b0;
        wait_txns(4, 100, "rst_mid");
        check("rst_mid_at_idx3", 32'(bus_addr), 32'h24);
        reset = 1'b1;
        #1;
        check_idle_outputs("rst_mid");
        tick(3);
        reset = 1'b0;
        tick(20);
        check("rst_mid_no_done", 32'(sd_cnt), 32'd0);
        check("rst_mid_no_ack",  32'(ack_cnt), 32'd0);
        check("rst_mid_no_txn",  32'(txn_addr.size()), 32'd4);
        check("rst_mid_idle",    32'(busy), 32'd0);
        clear_logs();
        start_sweep = 1'b1;
        tick(1);
        start_sweep = 1'b0;
        wait_sweeps(1, 200, "rst_after");
        check_reads(0, "rst_after");

`ifdef SWEEP_TIMEOUT_EN
        // bus_done withheld for index 5: abort after 255 cycles of waiting
        tick(2);
        clear_logs();
        fix_lat   = 2;
        hold_en   = 1;
        hold_addr = 8'h26;
        start_sweep = 1'b1;
        tick(1);
        start_sweep = 1'b0;
        wait_txns(6, 100, "tmo");
        t0 = 0;
        for (int n = 0; n < 400 && t0 == 0; n++) begin
            tick(1);
            if (!busy) t0 = cyc;
        end
        if (txn_cyc.size() >= 6)
            check("tmo_abort_cyc", 32'(t0 - txn_cyc[5]), 32'd255);
        check("tmo_bus_err",  32'(bus_err), 32'd1);
        check("tmo_no_done",  32'(sd_cnt), 32'd0);
        check("tmo_strobes",  32'(st_idx.size()), 32'd5);
        check("tmo_reg_rd",   32'(reg_rd), 32'd1);
        tick(10);
        check("tmo_sticky",   32'(bus_err), 32'd1);
        hold_en = 0;
`else
        check("no_tmo_bus_err", 32'(bus_err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
